// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_pkg
//  Description : Shared definitions for the multicycle controller: state
//                codes, opcode/funct values and datapath select encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

    // State codes are visible on oState, so the values are fixed.
    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_IEXEC  = 4'd10,
        ST_IWB    = 4'd11,
        ST_JR     = 4'd12,
        ST_TRAP   = 4'd13
    } state_t;

    // Opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'd0;
    localparam logic [5:0] c_OP_J     = 6'd2;
    localparam logic [5:0] c_OP_JAL   = 6'd3;
    localparam logic [5:0] c_OP_BEQ   = 6'd4;
    localparam logic [5:0] c_OP_ADDI  = 6'd8;
    localparam logic [5:0] c_OP_SLTI  = 6'd10;
    localparam logic [5:0] c_OP_ANDI  = 6'd12;
    localparam logic [5:0] c_OP_ORI   = 6'd13;
    localparam logic [5:0] c_OP_XORI  = 6'd14;
    localparam logic [5:0] c_OP_LW    = 6'd35;
    localparam logic [5:0] c_OP_SW    = 6'd43;

    // Funct codes
    localparam logic [5:0] c_FN_SLL = 6'd0;
    localparam logic [5:0] c_FN_SRL = 6'd2;
    localparam logic [5:0] c_FN_SRA = 6'd3;
    localparam logic [5:0] c_FN_JR  = 6'd8;

    // ALUOp
    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b01;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b10;
    localparam logic [1:0] c_ALUOP_ITYPE = 2'b11;

    // ALUSrcB
    localparam logic [1:0] c_SRCB_B       = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR    = 2'b01;
    localparam logic [1:0] c_SRCB_IMM     = 2'b10;
    localparam logic [1:0] c_SRCB_IMM_SH2 = 2'b11;

    // PCSrc
    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] c_PCSRC_REGA   = 2'b11;

    // RegDST
    localparam logic [1:0] c_REGDST_RT = 2'b00;
    localparam logic [1:0] c_REGDST_RD = 2'b01;
    localparam logic [1:0] c_REGDST_RA = 2'b10;

    // MemToReg
    localparam logic [1:0] c_M2R_ALUOUT = 2'b00;
    localparam logic [1:0] c_M2R_MDR    = 2'b01;
    localparam logic [1:0] c_M2R_PC     = 2'b10;

    // Shift-by-immediate R-type ops take their shift amount from shamt.
    function automatic logic is_shamt_funct(input logic [5:0] fn);
        return (fn == c_FN_SLL) || (fn == c_FN_SRL) || (fn == c_FN_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mc_wait_timer
//  Description : Memory-wait watchdog. Counts consecutive cycles in which the
//                controller is stalled on memory; flags expiry on the cycle
//                whose stall would bring the count to TIMEOUT_CYCLES.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                i_waiting  - controller in a wait state with memory not ready
//                o_expired  - this stall cycle is the TIMEOUT_CYCLES-th
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_waiting,
    output logic o_expired
);

    localparam int              c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] count_q;
    logic [c_CNT_W-1:0] count_d;

    // A ready cycle in a wait state always leaves that state, and every
    // other state is not a wait, so any non-stall cycle restarts the count.
    // This gives "clear on entry" without needing the next-state value.
    always_comb begin
        count_d = i_waiting ? (count_q + 1'b1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = i_waiting && (count_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Moore-style control FSM for a multicycle MIPS-like datapath.
//                Optional memory-wait watchdog enabled by defining
//                MCCTRL_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
//  Ports       : iClk, iRst           - clock / sync active-high reset
//                iIR_opcode, iIR_func - instruction register fields
//                iMemReady, iZero     - memory handshake, ALU zero flag
//                o*                   - datapath enables and selects
//                oState               - current state code
//                oIllegal, oTimeout   - trap flags
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [5:0] iIR_opcode,
    input  logic [5:0] iIR_func,
    input  logic       iMemReady,
    input  logic       iZero,
    output logic       oPCWrite,
    output logic       oIRWrite,
    output logic       oMemRead,
    output logic       oMemWrite,
    output logic       oIorD,
    output logic       oRegWrite,
    output logic       oALUSrcA,
    output logic       oShamtSel,
    output logic [1:0] oALUSrcB,
    output logic [1:0] oALUOp,
    output logic [1:0] oPCSrc,
    output logic [1:0] oRegDST,
    output logic [1:0] oMemToReg,
    output logic [3:0] oState,
    output logic       oIllegal,
    output logic       oTimeout
);

    state_t state_q;
    state_t state_d;
    logic   w_wait_state;
    logic   w_timeout_hit;
    logic   w_timeout_flag;

    assign w_wait_state = (state_q == ST_FETCH) || (state_q == ST_MEMRD) ||
                          (state_q == ST_MEMWR);

`ifdef MCCTRL_TIMEOUT_EN
    logic timeout_q;
    logic timeout_d;

    mc_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (iClk),
        .rst       (iRst),
        .i_waiting (w_wait_state && !iMemReady),
        .o_expired (w_timeout_hit)
    );

    // Sticky until reset so software can tell a timeout trap from an
    // illegal-opcode trap.
    always_comb begin
        timeout_d = timeout_q | w_timeout_hit;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign w_timeout_flag = timeout_q;
`else
    logic w_unused_timeout_cfg;

    assign w_timeout_hit        = 1'b0;
    assign w_timeout_flag       = 1'b0;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (iMemReady) state_d = ST_DECODE;
            ST_DECODE: begin
                case (iIR_opcode)
                    c_OP_LW, c_OP_SW:  state_d = ST_MEMADR;
                    c_OP_RTYPE:        state_d = (iIR_func == c_FN_JR) ? ST_JR : ST_EXEC;
                    c_OP_BEQ:          state_d = ST_BRANCH;
                    c_OP_J, c_OP_JAL:  state_d = ST_JUMP;
                    c_OP_ADDI, c_OP_SLTI, c_OP_ANDI,
                    c_OP_ORI, c_OP_XORI: state_d = ST_IEXEC;
                    default:           state_d = ST_TRAP;
                endcase
            end
            ST_MEMADR: state_d = (iIR_opcode == c_OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  if (iMemReady) state_d = ST_MEMWB;
            ST_MEMWB:  state_d = ST_FETCH;
            ST_MEMWR:  if (iMemReady) state_d = ST_FETCH;
            ST_EXEC:   state_d = ST_ALUWB;
            ST_ALUWB:  state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            ST_IEXEC:  state_d = ST_IWB;
            ST_IWB:    state_d = ST_FETCH;
            ST_JR:     state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_TRAP;
        endcase
        if (w_timeout_hit) begin
            state_d = ST_TRAP;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (state only, plus the two documented qualifiers)
    // ------------------------------------------------------------------
    always_comb begin
        oPCWrite  = 1'b0;
        oIRWrite  = 1'b0;
        oMemRead  = 1'b0;
        oMemWrite = 1'b0;
        oIorD     = 1'b0;
        oRegWrite = 1'b0;
        oALUSrcA  = 1'b0;
        oShamtSel = 1'b0;
        oALUSrcB  = c_SRCB_B;
        oALUOp    = c_ALUOP_ADD;
        oPCSrc    = c_PCSRC_ALU;
        oRegDST   = c_REGDST_RT;
        oMemToReg = c_M2R_ALUOUT;
        oIllegal  = 1'b0;
        oTimeout  = w_timeout_flag;
        oState    = state_q;

        case (state_q)
            ST_FETCH: begin
                oMemRead = 1'b1;
                oALUSrcB = c_SRCB_FOUR;
                oIRWrite = iMemReady;
                oPCWrite = iMemReady;
            end
            ST_DECODE: begin
                oALUSrcB = c_SRCB_IMM_SH2;
            end
            ST_MEMADR: begin
                oALUSrcA = 1'b1;
                oALUSrcB = c_SRCB_IMM;
            end
            ST_MEMRD: begin
                oMemRead = 1'b1;
                oIorD    = 1'b1;
            end
            ST_MEMWB: begin
                oRegWrite = 1'b1;
                oMemToReg = c_M2R_MDR;
            end
            ST_MEMWR: begin
                oMemWrite = 1'b1;
                oIorD     = 1'b1;
            end
            ST_EXEC: begin
                oALUSrcA  = 1'b1;
                oALUOp    = c_ALUOP_FUNCT;
                oShamtSel = is_shamt_funct(iIR_func);
            end
            ST_ALUWB: begin
                oRegWrite = 1'b1;
                oRegDST   = c_REGDST_RD;
            end
            ST_BRANCH: begin
                oALUSrcA = 1'b1;
                oALUOp   = c_ALUOP_SUB;
                oPCSrc   = c_PCSRC_ALUOUT;
                oPCWrite = iZero;
            end
            ST_JUMP: begin
                oPCSrc   = c_PCSRC_JUMP;
                oPCWrite = 1'b1;
                if (iIR_opcode == c_OP_JAL) begin
                    oRegWrite = 1'b1;
                    oRegDST   = c_REGDST_RA;
                    oMemToReg = c_M2R_PC;
                end
            end
            ST_IEXEC: begin
                oALUSrcA = 1'b1;
                oALUSrcB = c_SRCB_IMM;
                oALUOp   = c_ALUOP_ITYPE;
            end
            ST_IWB: begin
                oRegWrite = 1'b1;
            end
            ST_JR: begin
                oPCSrc   = c_PCSRC_REGA;
                oPCWrite = 1'b1;
            end
            ST_TRAP: begin
                oIllegal = !w_timeout_flag;
            end
            default: begin
            end
        endcase

        // Reset blanks everything in the same cycle so an in-flight memory
        // access or register write is abandoned immediately.
        if (iRst) begin
            oPCWrite  = 1'b0;
            oIRWrite  = 1'b0;
            oMemRead  = 1'b0;
            oMemWrite = 1'b0;
            oIorD     = 1'b0;
            oRegWrite = 1'b0;
            oALUSrcA  = 1'b0;
            oShamtSel = 1'b0;
            oALUSrcB  = '0;
            oALUOp    = '0;
            oPCSrc    = '0;
            oRegDST   = '0;
            oMemToReg = '0;
            oIllegal  = 1'b0;
            oTimeout  = 1'b0;
            oState    = '0;
        end
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: memory-wait limit in cycles, used only when MCCTRL_TIMEOUT_EN is defined.
REQ-002 iClk  in  1  single clock, rising edge.
REQ-003 iRst  in  1  synchronous, active-high reset.
REQ-004 iIR_opcode  in  6  opcode from the instruction register.
REQ-005 iIR_func  in  6  funct from the instruction register.
REQ-006 iMemReady  in  1  memory has completed the current read/write this cycle.
REQ-007 iZero  in  1  ALU zero flag.
REQ-008 oPCWrite, oIRWrite, oMemRead, oMemWrite, oIorD, oRegWrite, oALUSrcA, oShamtSel  out  1 each  datapath enables/selects.
REQ-009 oALUSrcB, oALUOp, oPCSrc, oRegDST, oMemToReg  out  2 each  datapath selects.
REQ-010 oState  out  4  current state code; oIllegal  out  1  trap flag; oTimeout  out  1  watchdog flag.

Function
REQ-011 Moore FSM, one state register; outputs SHALL decode from state only, except that oPCWrite/oIRWrite are qualified by iMemReady and iZero as stated below.
REQ-012 Encodings: ALUOp 00 add, 01 R-type funct, 10 subtract, 11 I-type. ALUSrcB 00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2. PCSrc 00 ALU result, 01 ALUOut, 10 jump target, 11 register A. RegDST 00 rt, 01 rd, 10 $31. MemToReg 00 ALUOut, 01 MDR, 10 PC.
REQ-013 States and codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, JR=12, TRAP=13.
REQ-014 FETCH: oMemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; oIRWrite=oPCWrite=iMemReady; stay until iMemReady=1, then go to DECODE.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target to ALUOut). Next state: opcode 35/43->MEMADR; 0 with funct 8->JR; 0 otherwise->EXEC; 4->BRANCH; 2/3->JUMP; 8/10/12/13/14->IEXEC; any other opcode->TRAP.
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; go to MEMRD (lw) or MEMWR (sw).
REQ-017 MEMRD: oMemRead=1, IorD=1; hold until iMemReady, then go to MEMWB. MEMWB: RegWrite=1, RegDST=00, MemToReg=01; then FETCH.
REQ-018 MEMWR: oMemWrite=1, IorD=1; hold until iMemReady, then FETCH. oMemWrite SHALL NOT drop before iMemReady.
REQ-019 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=01; oShamtSel=1 when funct is 0, 2 or 3. ALUWB: RegWrite=1, RegDST=01, MemToReg=00; then FETCH.
REQ-020 IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11. IWB: RegWrite=1, RegDST=00; then FETCH.
REQ-021 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=10, PCSrc=01, oPCWrite=iZero; then FETCH.
REQ-022 JUMP: PCSrc=10, oPCWrite=1; for opcode 3 also RegWrite=1, RegDST=10, MemToReg=10; then FETCH. JR: PCSrc=11, oPCWrite=1; then FETCH.
REQ-023 TRAP: oIllegal=1 and all enables 0; the FSM SHALL stay in TRAP until iRst.
REQ-024 Zero-wait latencies (cycles): R/I-type 4, lw 5, sw 4, beq/j/jal/jr 3; each cycle iMemReady is low in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
REQ-025 All signals not listed for a state SHALL be 0.

Reset
REQ-026 While iRst=1: state is FETCH and every output is 0 (output gating overrides FETCH decode); the first cycle after release is FETCH with normal outputs.
REQ-027 Reset asserted in any state, including a memory wait, SHALL abort the instruction without further writes on the next edge.

Configuration
REQ-028 MCCTRL_TIMEOUT_EN defined: a wait counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle iMemReady=0 there. When the count reaches TIMEOUT_CYCLES, the FSM goes to TRAP with oTimeout=1 (sticky until reset) and oIllegal=0.
REQ-029 MCCTRL_TIMEOUT_EN undefined: no counter; oTimeout tied 0; waits are unbounded.

Structure
REQ-030 Package mc_pkg SHALL hold the state enum, opcode/funct constants, and the ALUOp/ALUSrcB/PCSrc/RegDST/MemToReg encodings.
REQ-031 The optional watchdog SHALL be sub-module mc_wait_timer, instantiated only under MCCTRL_TIMEOUT_EN.

Verification
REQ-032 Pulse iRst during MEMRD -> next cycle state 0 with all outputs 0; after release, FETCH with oMemRead=1.
REQ-033 add (op 0, funct 32), iMemReady=1 -> oState 0,1,6,7; RegWrite=1 with RegDST=01 only in cycle 4.
REQ-034 lw, iMemReady low 3 cycles in MEMRD -> MemRead held 4 cycles; instruction completes in 8 cycles.
REQ-035 beq with iZero=0 -> no oPCWrite in BRANCH; with iZero=1 -> oPCWrite=1 and PCSrc=01.
REQ-036 Opcode 63 -> TRAP, oState=13, oIllegal=1 held for 20 cycles until iRst.
REQ-037 With MCCTRL_TIMEOUT_EN and TIMEOUT_CYCLES=4, iMemReady held 0 in FETCH -> TRAP with oTimeout=1 after 4 wait cycles; without the macro, the FSM remains in FETCH.
